line_clear_scanner: RTL and testbench
=====================================

# line_clear_scanner

Post-lock board compaction stage, directly upstream of the score keeper. On a piece-lock pulse it scans the playfield bottom to top and removes every completely filled row by copying surviving rows downward. It then zero-fills the vacated top rows and reports the number of cleared lines as a one-cycle `update` strobe with `num_lines`, which feeds the score keeper inputs of the same names. The board storage lives in the board module; this block reaches it only through a row read port and a row write port.

## Interface
Parameters:
- `BOARD_W`, default 10: cells per row (row vector width).
- `BOARD_H`, default 20: number of rows. Row 0 is the top row; row `BOARD_H-1` is the bottom row.

Ports:
- `Clk`, in, 1: 50 MHz system clock. One clock domain; all logic on its rising edge.
- `Reset`, in, 1: synchronous, active-high reset.
- `lock`, in, 1: single-cycle pulse; the active piece has been written into the board.
- `row_rd_addr`, out, `$clog2(BOARD_H)`: row being read.
- `row_rd_data`, in, `BOARD_W`: combinational read data for `row_rd_addr`, valid in the same cycle.
- `row_wr_en`, out, 1: write strobe, committed by the board module on the next `Clk` edge.
- `row_wr_addr`, out, `$clog2(BOARD_H)`: row address for the write.
- `row_wr_data`, out, `BOARD_W`: row contents for the write.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse at the end of every scan, including scans that clear zero rows.
- `update`, out, 1: one-cycle pulse, coincident with `done`, only when at least one line was cleared.
- `num_lines`, out, 3: cleared-line count, held from DONE until the next scan starts.

## Operation
- State machine: IDLE, SCAN, FILL, DONE.
- IDLE:
  - `lock` = 1 → SCAN.
  - On entry to SCAN: `rd_ptr` = `BOARD_H-1`, `wr_ptr` = `BOARD_H-1`, internal `cnt` = 0.
- SCAN, one row per cycle:
  - `row_rd_addr` = `rd_ptr`.
  - Row full (reduction-AND of `row_rd_data` = 1): `cnt` increments; no write.
  - Row not full:
    - If `rd_ptr` ≠ `wr_ptr`: write `row_rd_data` to `wr_ptr`.
    - In both cases `wr_ptr` decrements.
  - `rd_ptr` decrements each cycle.
  - Exit after the cycle with `rd_ptr` = 0: `cnt` = 0 → DONE; otherwise → FILL.
- FILL:
  - Each cycle writes all-zeros to `wr_ptr`, then `wr_ptr` decrements.
  - Exit to DONE after the cycle that writes row 0. FILL lasts exactly `cnt` cycles.
- DONE:
  - `done` = 1 for one cycle.
  - `update` = (`cnt` ≠ 0).
  - `num_lines` = min(`cnt`, 4). The full `cnt` is still used for compaction; only the reported value is clamped.
  - Next state: IDLE.
- `lock` outside IDLE is ignored; there is no queueing.
- `cnt` width is `$clog2(BOARD_H+1)`; it cannot wrap.
- `row_wr_en` is low in IDLE and DONE. `row_wr_addr` and `row_wr_data` are don't-care while `row_wr_en` = 0.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `update` 0, `num_lines` 0, `row_wr_en` 0, `row_rd_addr` 0.
- Latency:
  - `lock` sampled at edge E. SCAN occupies cycles E+1 .. E+`BOARD_H`.
  - FILL occupies the next `cnt` cycles.
  - `done` is high in cycle E+`BOARD_H`+`cnt`+1.
  - `busy` falls in the following cycle.
  - Worst case with a 4-line clear at default parameters: `done` at E+25.
- Back-to-back: `lock` in the cycle `busy` falls is accepted. `lock` in the DONE cycle is ignored.
- Mid-operation `Reset`: return to IDLE on that edge, with `row_wr_en` low from the next cycle. No partial `update` is issued. The board module is reset by the same signal.
- Read-before-write: in each cycle `wr_ptr` ≥ `rd_ptr`, so no unread row is ever overwritten.

## Configuration
- `LINE_CLEAR_STATS_EN` defined:
  - Adds output `total_lines` [15:0]: running sum of `num_lines`, updated in the DONE cycle.
  - Saturates at 16'hFFFF.
  - Reset value 0.
- Not defined: the port and its counter are absent; all other behaviour is identical.

## Structure
- Shared package `tetris_pkg`:
  - `BOARD_W` and `BOARD_H` constants, used as parameter defaults.
  - `ROW_AW` = `$clog2(BOARD_H)`.
  - `MAX_REPORT_LINES` = 4.
  - `clr_state_t` enum {IDLE, SCAN, FILL, DONE}.
- No sub-module. The full-row test is an inline reduction-AND; a single FSM module with its pointer and counter registers is sufficient.

## Test plan
- Empty board, `lock` → `done` at E+21, `update` = 0, `num_lines` = 0, no writes issued.
- Rows 18 and 19 full, row 17 = 10'h001 → `update` with `num_lines` = 2 at E+23. Afterwards row 19 = 10'h001, rows 0–1 zero, rows 2–17 hold former rows 0–15 (each moved down two rows); rows 2–18 match the pre-scan contents of rows 0–16.
- Rows 16–19 full → `num_lines` = 4 at E+25, rows 0–3 zeroed; then verify the score keeper digits read 1200.
- Rows 14–19 full (preloaded) → `num_lines` = 4 (clamped), all 6 rows removed, `done` at E+27.
- `lock` pulsed during SCAN and again in the DONE cycle → both ignored; exactly one `done`.
- `Reset` asserted at E+10 → `busy` = 0 next cycle, no `update`, `row_wr_en` = 0. A fresh `lock` afterwards completes normally.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared board geometry, scanner state encoding and line-count clamp helper.
package tetris_pkg;

    localparam int unsigned BOARD_W          = 10;
    localparam int unsigned BOARD_H          = 20;
    localparam int unsigned ROW_AW           = $clog2(BOARD_H);
    localparam int unsigned MAX_REPORT_LINES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } clr_state_t;

    // Reported count saturates; compaction still uses the full count.
    function automatic logic [2:0] clamp_lines(input int unsigned n);
        return (n > MAX_REPORT_LINES) ? 3'(MAX_REPORT_LINES) : 3'(n);
    endfunction

endpackage

// File: rtl/line_clear_scanner_if.sv
// Board row ports, lock/score strobes of the line clear scanner.
// total_lines exists only when LINE_CLEAR_STATS_EN is defined.
interface line_clear_scanner_if #(
    parameter int unsigned BOARD_W = tetris_pkg::BOARD_W,
    parameter int unsigned BOARD_H = tetris_pkg::BOARD_H
);
    localparam int unsigned AW = (BOARD_H > 1) ? $clog2(BOARD_H) : 1;

    logic               lock;
    logic [AW-1:0]      row_rd_addr;
    logic [BOARD_W-1:0] row_rd_data;
    logic               row_wr_en;
    logic [AW-1:0]      row_wr_addr;
    logic [BOARD_W-1:0] row_wr_data;
    logic               busy;
    logic               done;
    logic               update;
    logic [2:0]         num_lines;
`ifdef LINE_CLEAR_STATS_EN
    logic [15:0]        total_lines;
`endif

    modport master (
        input  lock, row_rd_data,
        output row_rd_addr, row_wr_en, row_wr_addr, row_wr_data,
        output busy, done, update, num_lines
`ifdef LINE_CLEAR_STATS_EN
        , output total_lines
`endif
    );

    modport slave (
        output lock, row_rd_data,
        input  row_rd_addr, row_wr_en, row_wr_addr, row_wr_data,
        input  busy, done, update, num_lines
`ifdef LINE_CLEAR_STATS_EN
        , input total_lines
`endif
    );

endinterface

// File: rtl/line_clear_scanner.sv
// Post-lock compaction: drops full rows bottom-up, zero-fills the top, reports count.
// Optional running total on bus.total_lines when LINE_CLEAR_STATS_EN is defined.
module line_clear_scanner #(
    parameter int unsigned BOARD_W = tetris_pkg::BOARD_W,
    parameter int unsigned BOARD_H = tetris_pkg::BOARD_H
) (
    input logic                  Clk,
    input logic                  Reset,
    line_clear_scanner_if.master bus
);
    import tetris_pkg::*;

    localparam int unsigned AW    = (BOARD_H > 1) ? $clog2(BOARD_H) : 1;
    localparam int unsigned CNT_W = $clog2(BOARD_H + 1);

    clr_state_t         state, state_nxt;
    logic [AW-1:0]      rd_ptr, rd_ptr_nxt;
    logic [AW-1:0]      wr_ptr, wr_ptr_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [BOARD_W-1:0] rd_row;
    logic               row_full;
    logic               wr_en_c;
    logic               wr_zero_c;
    logic [2:0]         lines_c;

    logic               busy_q;
    logic               done_q;
    logic               update_q;
    logic [2:0]         num_lines_q;

    assign rd_row   = bus.row_rd_data;
    assign row_full = &rd_row;
    assign lines_c  = clamp_lines(32'(cnt_nxt));

    // Next-state, pointer and write-port decode
    always_comb begin
        state_nxt  = state;
        rd_ptr_nxt = rd_ptr;
        wr_ptr_nxt = wr_ptr;
        cnt_nxt    = cnt;
        wr_en_c    = 1'b0;
        wr_zero_c  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.lock) begin
                    state_nxt  = SCAN;
                    rd_ptr_nxt = AW'(BOARD_H - 1);
                    wr_ptr_nxt = AW'(BOARD_H - 1);
                    cnt_nxt    = '0;
                end
            end
            SCAN: begin
                if (row_full) begin
                    cnt_nxt = cnt + CNT_W'(1);
                end else begin
                    wr_en_c    = (rd_ptr != wr_ptr);
                    wr_ptr_nxt = wr_ptr - AW'(1);
                end
                if (rd_ptr == '0) begin
                    state_nxt = (cnt_nxt == '0) ? DONE : FILL;
                end else begin
                    rd_ptr_nxt = rd_ptr - AW'(1);
                end
            end
            FILL: begin
                wr_en_c   = 1'b1;
                wr_zero_c = 1'b1;
                if (wr_ptr == '0) begin
                    state_nxt = DONE;
                end else begin
                    wr_ptr_nxt = wr_ptr - AW'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, pointers and registered status outputs
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            cnt         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            update_q    <= 1'b0;
            num_lines_q <= '0;
        end else begin
            state    <= state_nxt;
            rd_ptr   <= rd_ptr_nxt;
            wr_ptr   <= wr_ptr_nxt;
            cnt      <= cnt_nxt;
            busy_q   <= (state_nxt != IDLE);
            done_q   <= (state_nxt == DONE);
            update_q <= (state_nxt == DONE) && (cnt_nxt != '0);
            if ((state == IDLE) && bus.lock) begin
                num_lines_q <= '0;
            end else if (state_nxt == DONE) begin
                num_lines_q <= lines_c;
            end
        end
    end

`ifdef LINE_CLEAR_STATS_EN
    logic [15:0] total_q;
    logic [16:0] total_sum_c;

    assign total_sum_c = 17'(total_q) + 17'(lines_c);

    // Saturating running sum of reported lines
    always_ff @(posedge Clk) begin
        if (Reset) begin
            total_q <= '0;
        end else if (state_nxt == DONE) begin
            total_q <= total_sum_c[16] ? 16'hFFFF : total_sum_c[15:0];
        end
    end

    assign bus.total_lines = total_q;
`endif

    assign bus.row_rd_addr = rd_ptr;
    assign bus.row_wr_en   = wr_en_c;
    assign bus.row_wr_addr = wr_ptr;
    assign bus.row_wr_data = wr_zero_c ? '0 : rd_row;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.update      = update_q;
    assign bus.num_lines   = num_lines_q;

endmodule

// File: tb/tb_line_clear_scanner.sv
// Bench for line_clear_scanner: board memory model plus queue-based compaction reference.
module tb_line_clear_scanner;

    localparam int W = 10;
    localparam int H = 20;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;
    always #10 Clk = ~Clk;

    line_clear_scanner_if #(.BOARD_W(W), .BOARD_H(H)) bus ();

    line_clear_scanner #(.BOARD_W(W), .BOARD_H(H)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.master)
    );

    logic [W-1:0] board   [H];
    logic [W-1:0] ld_rows [H];
    logic [W-1:0] exp_rows[H];
    logic         ld_en  = 1'b0;
    int           writes = 0;

    int checks = 0;
    int errors = 0;
    int exp_cnt, exp_moves, exp_lines, exp_total;

    assign bus.row_rd_data = board[bus.row_rd_addr];

    // Board storage: reset-cleared, bulk preload from the bench, DUT row writes
    always @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < H; i++) board[i] <= '0;
        end else if (ld_en) begin
            for (int i = 0; i < H; i++) board[i] <= ld_rows[i];
        end else if (bus.row_wr_en) begin
            board[bus.row_wr_addr] <= bus.row_wr_data;
            writes <= writes + 1;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: keep non-full rows in bottom-up order, stack them at the bottom
    task automatic model();
        int q[$];
        int pos;
        exp_cnt   = 0;
        exp_moves = 0;
        for (int r = H - 1; r >= 0; r--) begin
            if (ld_rows[r] == {W{1'b1}}) exp_cnt++;
            else q.push_back(r);
        end
        for (int r = 0; r < H; r++) exp_rows[r] = '0;
        pos = H - 1;
        foreach (q[k]) begin
            exp_rows[pos] = ld_rows[q[k]];
            if (q[k] != pos) exp_moves++;
            pos--;
        end
        exp_lines = (exp_cnt > 4) ? 4 : exp_cnt;
    endtask

    task automatic gen(input int pct_full);
        logic [W-1:0] v;
        for (int r = 0; r < H; r++) begin
            if (int'($urandom_range(99)) < pct_full) begin
                ld_rows[r] = {W{1'b1}};
            end else begin
                v = W'($urandom);
                if (v == {W{1'b1}}) v[0] = 1'b0;
                ld_rows[r] = v;
            end
        end
    endtask

    task automatic load();
        @(negedge Clk);
        ld_en = 1'b1;
        @(negedge Clk);
        ld_en = 1'b0;
    endtask

    // mode 0 plain, 1 stray locks in SCAN and DONE, 2 reset at E+10, 3 back-to-back lock
    task automatic run_scan(input int mode);
        int done_c, done_cnt, upd_cnt, w0;
        int upd, nl, busy_after, nl_after, busy_b2b, exp_dones;
        model();
        w0 = writes;
        done_c = 0; done_cnt = 0; upd_cnt = 0;
        upd = 0; nl = 0; busy_after = -1; nl_after = -1; busy_b2b = -1;
        exp_dones = (mode == 3) ? 2 : 1;
        @(negedge Clk);
        bus.lock = 1'b1;
        @(posedge Clk);
        for (int c = 1; c <= 90; c++) begin
            @(negedge Clk);
            bus.lock = 1'b0;
            if (c == 1) begin
                chk("busy_start", int'(bus.busy), 1);
                chk("rd_addr_start", int'(bus.row_rd_addr), H - 1);
            end
            if (mode == 1 && c == 5) bus.lock = 1'b1;
            if (mode == 2 && c == 10) Reset = 1'b1;
            if (mode == 2 && c == 11) begin
                chk("busy_after_reset", int'(bus.busy), 0);
                chk("wr_en_after_reset", int'(bus.row_wr_en), 0);
                chk("update_after_reset", int'(bus.update), 0);
                Reset = 1'b0;
                exp_total = 0;
            end
            if (bus.update) upd_cnt++;
            if (bus.done) begin
                done_cnt++;
                if (done_c == 0) begin
                    done_c = c;
                    upd    = int'(bus.update);
                    nl     = int'(bus.num_lines);
                    chk("wr_en_in_done", int'(bus.row_wr_en), 0);
                end
                if (mode == 1) bus.lock = 1'b1;
            end
            if (done_c != 0 && c == done_c + 1) begin
                busy_after = int'(bus.busy);
                nl_after   = int'(bus.num_lines);
                if (mode == 3) bus.lock = 1'b1;
            end
            if (done_c != 0 && c == done_c + 2) busy_b2b = int'(bus.busy);
        end
        if (mode == 2) begin
            chk("done_after_reset", done_cnt, 0);
            chk("update_pulses_reset", upd_cnt, 0);
            chk("idle_after_reset", int'(bus.busy), 0);
        end else begin
            exp_total = exp_total + exp_lines;
            if (exp_total > 16'hFFFF) exp_total = 16'hFFFF;
            chk("done_count", done_cnt, exp_dones);
            chk("done_cycle", done_c, H + exp_cnt + 1);
            chk("update_at_done", upd, (exp_cnt != 0) ? 1 : 0);
            chk("num_lines", nl, exp_lines);
            chk("update_pulses", upd_cnt, (exp_cnt != 0) ? 1 : 0);
            chk("busy_after_done", busy_after, 0);
            chk("num_lines_held", nl_after, exp_lines);
            if (mode == 3) chk("busy_back_to_back", busy_b2b, 1);
            else           chk("busy_idle_after", busy_b2b, 0);
            chk("row_writes", writes - w0, exp_cnt + exp_moves);
            for (int r = 0; r < H; r++)
                chk($sformatf("board_row%0d", r), int'(board[r]), int'(exp_rows[r]));
`ifdef LINE_CLEAR_STATS_EN
            chk("total_lines", int'(bus.total_lines), exp_total);
`endif
        end
    endtask

    initial begin
        bus.lock  = 1'b0;
        exp_total = 0;
        Reset     = 1'b1;
        repeat (3) @(negedge Clk);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_update", int'(bus.update), 0);
        chk("rst_num_lines", int'(bus.num_lines), 0);
        chk("rst_wr_en", int'(bus.row_wr_en), 0);
        chk("rst_rd_addr", int'(bus.row_rd_addr), 0);
        Reset = 1'b0;

        // Empty board: done at E+21, no writes
        for (int r = 0; r < H; r++) ld_rows[r] = '0;
        load();
        run_scan(0);

        // Two bottom rows full, marker row above them
        gen(0);
        ld_rows[17] = 10'h001;
        ld_rows[18] = {W{1'b1}};
        ld_rows[19] = {W{1'b1}};
        load();
        run_scan(0);

        // Four-line clear
        gen(0);
        for (int r = 16; r < H; r++) ld_rows[r] = {W{1'b1}};
        load();
        run_scan(0);

        // Six full rows: reported count clamps to 4
        gen(0);
        for (int r = 14; r < H; r++) ld_rows[r] = {W{1'b1}};
        load();
        run_scan(0);

        // Fully filled board
        for (int r = 0; r < H; r++) ld_rows[r] = {W{1'b1}};
        load();
        run_scan(0);

        gen(30);
        load();
        run_scan(1);

        gen(25);
        load();
        run_scan(3);

        gen(30);
        load();
        run_scan(2);

        gen(30);
        load();
        run_scan(0);

        for (int n = 0; n < 8; n++) begin
            gen(int'($urandom_range(60)));
            load();
            run_scan(0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
